// File: rtl/atmospheric_light_inverter.sv
// atmospheric_light_inverter: computes floor(65536/A) for three channels with one shared restoring divider
module atmospheric_light_inverter (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  A_R,
  input  logic [7:0]  A_G,
  input  logic [7:0]  A_B,
  output logic [15:0] Inv_R,
  output logic [15:0] Inv_G,
  output logic [15:0] Inv_B,
  output logic        busy,
  output logic        done
);
  localparam logic [15:0] INV_MAX = 16'd65535;
  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
  state_t      state_q, state_d;
  logic [1:0]  ch_q, ch_d;
  logic [8:0]  rem_q, rem_d, rem_n;
  logic [16:0] quo_q, quo_d, quo_n;
  logic [4:0]  step_q, step_d;
  logic [7:0]  ar_q, ar_d, ag_q, ag_d, ab_q, ab_d, div;
  logic [15:0] hold_r_q, hold_r_d, hold_g_q, hold_g_d, res;
  logic [15:0] inv_r_q, inv_r_d, inv_g_q, inv_g_d, inv_b_q, inv_b_d;
  logic [9:0]  t;
  logic        ge;
  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    step_d   = step_q;
    ar_d     = ar_q;
    ag_d     = ag_q;
    ab_d     = ab_q;
    hold_r_d = hold_r_q;
    hold_g_d = hold_g_q;
    inv_r_d  = inv_r_q;
    inv_g_d  = inv_g_q;
    inv_b_d  = inv_b_q;
    div      = ch_q == 2'd0 ? ar_q : ch_q == 2'd1 ? ag_q : ab_q;
    // dividend 0x10000 has a single one, at bit 16
    t        = {rem_q, step_q == 5'd16};
    ge       = t >= {2'b0, div};
    rem_n    = ge ? 9'(t - {2'b0, div}) : t[8:0];
    quo_n    = 17'({quo_q, ge});
    res      = quo_n[16] ? INV_MAX : quo_n[15:0];
    case (state_q)
      IDLE: if (start) begin
        state_d = DIV;
        ar_d    = A_R;
        ag_d    = A_G;
        ab_d    = A_B;
        ch_d    = 2'd0;
        rem_d   = '0;
        quo_d   = '0;
        step_d  = 5'd16;
      end
      DIV: begin
        rem_d  = rem_n;
        quo_d  = quo_n;
        step_d = step_q - 5'd1;
        if (step_q == 5'd0) begin
          rem_d  = '0;
          quo_d  = '0;
          step_d = 5'd16;
          ch_d   = ch_q + 2'd1;
          if (ch_q == 2'd0) hold_r_d = res;
          if (ch_q == 2'd1) hold_g_d = res;
          if (ch_q == 2'd2) begin
            inv_r_d = hold_r_q;
            inv_g_d = hold_g_q;
            inv_b_d = res;
            ch_d    = 2'd0;
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ch_q     <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      step_q   <= '0;
      ar_q     <= '0;
      ag_q     <= '0;
      ab_q     <= '0;
      hold_r_q <= '0;
      hold_g_q <= '0;
      inv_r_q  <= '0;
      inv_g_q  <= '0;
      inv_b_q  <= '0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      step_q   <= step_d;
      ar_q     <= ar_d;
      ag_q     <= ag_d;
      ab_q     <= ab_d;
      hold_r_q <= hold_r_d;
      hold_g_q <= hold_g_d;
      inv_r_q  <= inv_r_d;
      inv_g_q  <= inv_g_d;
      inv_b_q  <= inv_b_d;
    end
  end
  assign Inv_R = inv_r_q;
  assign Inv_G = inv_g_q;
  assign Inv_B = inv_b_q;
  assign busy  = state_q != IDLE;
  assign done  = state_q == DONE;
endmodule

// File: doc/atmospheric_light_inverter.md
# atmospheric_light_inverter

Iterative reciprocal unit that produces the inverted atmospheric light values (Q0.16) that the transmission-estimate multipliers consume as `Ac_Inv`. Once atmospheric light estimation finishes, it accepts the three 8-bit channel values A_R, A_G, A_B and computes floor(65536 / Ac) for each with a shared 1-bit-per-cycle restoring divider. All three results are presented together with a one-cycle `done` pulse. Latency is fixed and does not depend on the data, so the frame controller can schedule around it.

## Interface
- `INV_MAX`, 16'd65535: saturation value for a reciprocal that does not fit in Q0.16.
- `clk` input 1: system clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: request pulse. Sampled only when `busy`=0.
- `A_R`, `A_G`, `A_B` input 8 each: atmospheric light per channel. Latched on the edge that accepts `start`.
- `Inv_R`, `Inv_G`, `Inv_B` output 16 each: floor(65536/Ac) in Q0.16, saturated to `INV_MAX`. Registered; hold their value until the next `done`.
- `busy` output 1: high whenever the state is not IDLE.
- `done` output 1: single-cycle pulse marking the cycle in which new `Inv_*` values first appear.

## Operation
- States:
  - IDLE: `busy`=0. On `start`=1, latch `A_*`, set ch=0, rem=0, quotient=0, step=16, and go to DIV.
  - DIV: performs one restoring step per cycle (17 steps per channel, 51 in total), then goes to DONE.
  - DONE: `done`=1 for exactly one cycle, then returns to IDLE.
- Dividend is the 17-bit constant 0x10000, consumed MSB first (dividend bit [step]).
- Each DIV step:
  - t = {rem, bit} (10 bits).
  - If t >= {2'b0, divisor}: rem ← t − divisor and shift in quotient bit 1.
  - Otherwise: rem ← t and shift in 0.
  - rem is 9 bits wide; quotient is 17 bits.
- When step reaches 0 for a channel:
  - Result = (quotient > 0xFFFF) ? `INV_MAX` : quotient[15:0].
  - Store the result in an internal holding register for the current channel.
  - Advance ch (0=R, 1=G, 2=B) and reinitialise rem, quotient and step.
- After ch=2 completes, all three `Inv_*` output registers load from the holding registers on the same edge that asserts `done`.
- Divisor 0: restoring logic naturally produces all ones (0x1FFFF), which saturates to `INV_MAX`. No special path; latency is unchanged.
- Divisor 1: 0x10000 saturates to `INV_MAX`.
- Divisors 2..255 never saturate.
- `start` while `busy`=1, including the DONE cycle, is ignored. It is not queued.
- `A_*` changes after acceptance have no effect on the results.
- Reset values:
  - `Inv_R`/`Inv_G`/`Inv_B` = 0, `busy` = 0, `done` = 0.
  - State IDLE; all internal registers 0.
- Reset mid-operation abandons the computation. Outputs go to 0, not to the previous results, and no `done` pulse is produced.

## Timing
- Let E0 be the rising edge that samples `start`=1 in IDLE.
- `busy` goes high after E0 and drops after E52.
- E1–E17 compute R, E18–E34 compute G, E35–E51 compute B.
- E51 loads `Inv_*` and raises `done`; `done` falls at E52.
- Latency from start to done is 51 cycles. Minimum start-to-start interval is 53 cycles: the earliest next accept is at E53.
- `start` held high continuously re-triggers at E53, E106, and so on.
- `Inv_*` are stable at every edge except E51.
- All outputs come straight from registers; there is no combinational path from inputs to outputs.

## Test plan
- Reset, then `start` with A=(255,128,3): `done` rises exactly 51 edges after acceptance and `busy` spans E0→E52. Results are `Inv`=(257, 512, 21845).
- A=(0,1,2): results are `Inv`=(65535, 65535, 32768), with the same 51-cycle latency.
- A=(200,100,7), then `start` pulsed at E10 and during the DONE cycle: both pulses are ignored. Results are (327, 655, 9362), exactly one `done` appears, and `Inv_*` from the previous run hold until E51.
- `start` held high for 200 cycles with A=(50,50,50): a `done` pulse appears at E51, E104 and E157, and `Inv`=1310 on every channel.
- `rst` asserted asynchronously at E30 of a run with A=(9,9,9): all outputs read 0 immediately. After release, no `done` appears until a new `start`, and a fresh run yields 7281.
- Sweep A=0..255 on all channels against the model min(floor(65536/A), 65535), with A=0 mapped to 65535. Every result must match exactly.
